// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter.
// Accepts a byte on a level-sensitive start/ready handshake and sends it on tx as
// start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request to send data (level-sensitive, only looked at while idle)
//   data  - byte to send, sampled on the accepting edge only
//   tx    - serial line, idle high, registered
//   ready - high while idle and able to accept a byte, registered
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY       = 0,  // 0 none, 1 odd, 2 even
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    if (CLKS_PER_BIT < 2 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : gen_param_check
        $fatal(1, "uart_tx: illegal parameter combination");
    end

    localparam int unsigned        TIMER_W   = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic               par_bit;
    logic               stop_cnt;
    logic               bit_done;

    assign bit_done = (timer == TIMER_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            timer    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            ready    <= 1'b1;
        end else begin
            // Bit timer free-runs in every non-idle state and wraps at the end of a bit.
            if (state != StIdle) begin
                timer <= bit_done ? '0 : timer + TIMER_W'(1);
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        shift   <= data;
                        // Parity is fixed at accept time so mid-frame data changes are harmless.
                        par_bit <= (PARITY == 1) ? ~^data : ^data;
                        state   <= StStart;
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        state   <= StData;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                StData: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                state <= StPar;
                                tx    <= par_bit;
                            end else begin
                                state    <= StStop;
                                stop_cnt <= 1'b0;
                                tx       <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end
                end
                StPar: begin
                    if (bit_done) begin
                        state    <= StStop;
                        stop_cnt <= 1'b0;
                        tx       <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        if (stop_cnt == LAST_STOP) begin
                            state <= StIdle;
                            ready <= 1'b1;
                            tx    <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CLKS_PER_BIT=4.
// Three instances share the stimulus: no parity/1 stop, even parity/1 stop,
// odd parity/2 stops. sel chooses which instance the frame checker observes.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       tx0, rdy0, tx_e, rdy_e, tx_o, rdy_o;
    logic [1:0] sel;
    logic       tx_m, rdy_m;

    int checks;
    int errors;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .tx(tx0), .ready(rdy0)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .start(start), .data(data), .tx(tx_e), .ready(rdy_e)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut_odd (
        .clk(clk), .rst(rst), .start(start), .data(data), .tx(tx_o), .ready(rdy_o)
    );

    always_comb begin
        tx_m  = tx0;
        rdy_m = rdy0;
        case (sel)
            2'd1: begin tx_m = tx_e; rdy_m = rdy_e; end
            2'd2: begin tx_m = tx_o; rdy_m = rdy_o; end
            default: begin tx_m = tx0; rdy_m = rdy0; end
        endcase
    end

    always #5 if (clk_en) clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
    endtask

    // Called just after the accepting edge. Checks tx and ready every cycle of the
    // frame, then checks the idle state after the final edge of the frame.
    task automatic check_frame(input logic [7:0] b, input int has_par, input logic par,
                               input int nstop, input bit toggle);
        int   nb;
        logic exp_bit;
        nb = 9 + has_par + nstop;
        for (int k = 0; k < nb * CPB; k++) begin
            int j;
            j = k / CPB;
            if (j == 0)                       exp_bit = 1'b0;
            else if (j <= 8)                  exp_bit = b[j-1];
            else if (has_par != 0 && j == 9)  exp_bit = par;
            else                              exp_bit = 1'b1;
            chk($sformatf("tx byte %h bit %0d", b, j), tx_m, exp_bit);
            chk($sformatf("ready low byte %h cyc %0d", b, k), rdy_m, 1'b0);
            if (toggle) begin
                start = 1'(k % 2);
                data  = 8'hFF;
            end
            step();
        end
        chk($sformatf("ready end byte %h", b), rdy_m, 1'b1);
        chk($sformatf("tx end byte %h", b), tx_m, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        clk_en = 1'b0;
        rst    = 1'b0;
        start  = 1'b0;
        data   = 8'h00;
        sel    = 2'd0;

        // Reset with the clock stopped.
        #3 rst = 1'b1;
        #1;
        chk("reset tx0", tx0, 1'b1);
        chk("reset ready0", rdy0, 1'b1);
        chk("reset tx_e", tx_e, 1'b1);
        chk("reset ready_e", rdy_e, 1'b1);
        chk("reset tx_o", tx_o, 1'b1);
        chk("reset ready_o", rdy_o, 1'b1);
        #2 clk_en = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle tx", tx0, 1'b1);
            chk("idle ready", rdy0, 1'b1);
        end

        // Single frame 0xA5, no parity.
        data  = 8'hA5;
        start = 1'b1;
        step();
        start = 1'b0;
        check_frame(8'hA5, 0, 1'b0, 1, 1'b0);
        step();
        chk("idle after frame ready", rdy0, 1'b1);

        // Streaming with start held high; next byte is set on each ready rise.
        data  = 8'h00;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_frame(8'(i), 0, 1'b0, 1, 1'b0);
            data = data + 8'h01;
        end
        start = 1'b0;

        // Even parity on 0x07.
        reset_all();
        sel   = 2'd1;
        data  = 8'h07;
        start = 1'b1;
        step();
        start = 1'b0;
        check_frame(8'h07, 1, 1'b1, 1, 1'b0);

        // Odd parity on 0x07 with two stop bits (48-cycle frame).
        reset_all();
        sel   = 2'd2;
        data  = 8'h07;
        start = 1'b1;
        step();
        start = 1'b0;
        check_frame(8'h07, 1, 1'b0, 2, 1'b0);

        // Busy immunity: start toggles and data goes to 0xFF during the frame.
        reset_all();
        sel   = 2'd0;
        data  = 8'h3C;
        start = 1'b1;
        step();
        start = 1'b0;
        check_frame(8'h3C, 0, 1'b0, 1, 1'b1);
        // start is high at the end of the frame: 0xFF goes out after one ready cycle.
        step();
        start = 1'b0;
        check_frame(8'hFF, 0, 1'b0, 1, 1'b0);

        // Reset during data bit 3 of 0x55 (bit 3 is 0).
        reset_all();
        data  = 8'h55;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (17) step();
        chk("mid-frame tx before reset", tx0, 1'b0);
        chk("mid-frame ready before reset", rdy0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid-frame reset tx", tx0, 1'b1);
        chk("mid-frame reset ready", rdy0, 1'b1);
        rst = 1'b0;
        step();
        chk("post-reset idle ready", rdy0, 1'b1);
        chk("post-reset idle tx", tx0, 1'b1);
        data  = 8'h81;
        start = 1'b1;
        step();
        start = 1'b0;
        check_frame(8'h81, 0, 1'b0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
